// File: rtl/prince_word_ctrl_pkg.sv
// Shared widths and FSM encoding for the PRINCE word-serial front end.
package prince_word_ctrl_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned KEY_WORDS = 4;
  localparam int unsigned BLK_WORDS = 2;
  localparam int unsigned KEY_W     = WORD_W * KEY_WORDS;
  localparam int unsigned BLK_W     = WORD_W * BLK_WORDS;
  localparam int unsigned KEY_CNT_W = $clog2(KEY_WORDS);
  localparam int unsigned BLK_CNT_W = $clog2(BLK_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_OUT_HI = 2'd2,
    ST_OUT_LO = 2'd3
  } state_t;

endpackage

// File: rtl/prince_word_ctrl.sv
// Packs 32-bit key/block words into the PRINCE core inputs, waits the core
// latency, then streams the 64-bit result back as two words.
module prince_word_ctrl
  import prince_word_ctrl_pkg::*;
#(
  parameter int unsigned CORE_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_sel,
  input  logic              in_enc,
  output logic              core_enc,
  output logic [BLK_W-1:0]  core_pt,
  output logic [KEY_W-1:0]  core_key,
  input  logic [BLK_W-1:0]  core_ct,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  output logic              key_loaded,
  output logic              err,
  input  logic              err_clr
);

  localparam int unsigned LAT_W = (CORE_LAT < 2) ? 1 : $clog2(CORE_LAT + 1);

  state_t                    state, state_n;
  logic [KEY_CNT_W-1:0]      key_cnt, key_cnt_n;
  logic [BLK_CNT_W-1:0]      blk_cnt, blk_cnt_n;
  logic [KEY_W-WORD_W-1:0]   key_sr, key_sr_n;
  logic [BLK_W-WORD_W-1:0]   blk_sr, blk_sr_n;
  logic [LAT_W-1:0]          lat_cnt, lat_cnt_n;
  logic [WORD_W-1:0]         res_lo, res_lo_n;
  logic                      in_ready_n, core_enc_n, out_valid_n, out_last_n;
  logic                      key_loaded_n, err_n;
  logic [BLK_W-1:0]          core_pt_n;
  logic [KEY_W-1:0]          core_key_n;
  logic [WORD_W-1:0]         out_data_n;
  logic                      accept;

  assign accept = in_valid & in_ready & (state == ST_IDLE);

  // Next-state and next-output logic; every register holds unless updated below.
  always_comb begin
    state_n      = state;
    key_cnt_n    = key_cnt;
    blk_cnt_n    = blk_cnt;
    key_sr_n     = key_sr;
    blk_sr_n     = blk_sr;
    lat_cnt_n    = lat_cnt;
    res_lo_n     = res_lo;
    in_ready_n   = in_ready;
    core_enc_n   = core_enc;
    core_pt_n    = core_pt;
    core_key_n   = core_key;
    out_valid_n  = out_valid;
    out_data_n   = out_data;
    out_last_n   = out_last;
    key_loaded_n = key_loaded;
    err_n        = err;

    case (state)
      ST_IDLE: begin
        in_ready_n = 1'b1;
        if (accept) begin
          if (in_sel) begin
            key_sr_n = (KEY_W-WORD_W)'({key_sr, in_data});
            if (key_cnt == '0) key_loaded_n = 1'b0;
            if (key_cnt == KEY_CNT_W'(KEY_WORDS - 1)) begin
              core_key_n   = {key_sr, in_data};
              key_loaded_n = 1'b1;
              key_cnt_n    = '0;
            end else begin
              key_cnt_n = key_cnt + KEY_CNT_W'(1);
            end
          end else begin
            blk_sr_n = (BLK_W-WORD_W)'({blk_sr, in_data});
            if (blk_cnt == BLK_CNT_W'(BLK_WORDS - 1)) begin
              blk_cnt_n = '0;
              // A block without a complete key is discarded and flagged.
              if (key_loaded) begin
                core_pt_n  = {blk_sr, in_data};
                core_enc_n = in_enc;
                lat_cnt_n  = LAT_W'(CORE_LAT);
                in_ready_n = 1'b0;
                state_n    = ST_WAIT;
              end else begin
                err_n = 1'b1;
              end
            end else begin
              blk_cnt_n = blk_cnt + BLK_CNT_W'(1);
            end
          end
        end
      end
      ST_WAIT: begin
        if (lat_cnt == '0) begin
          res_lo_n    = core_ct[WORD_W-1:0];
          out_data_n  = core_ct[BLK_W-1:WORD_W];
          out_valid_n = 1'b1;
          out_last_n  = 1'b0;
          state_n     = ST_OUT_HI;
        end else begin
          lat_cnt_n = lat_cnt - LAT_W'(1);
        end
      end
      ST_OUT_HI: begin
        if (out_ready) begin
          out_data_n = res_lo;
          out_last_n = 1'b1;
          state_n    = ST_OUT_LO;
        end
      end
      ST_OUT_LO: begin
        if (out_ready) begin
          out_valid_n = 1'b0;
          out_last_n  = 1'b0;
          out_data_n  = '0;
          in_ready_n  = 1'b1;
          state_n     = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (err_clr) err_n = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      key_cnt    <= '0;
      blk_cnt    <= '0;
      key_sr     <= '0;
      blk_sr     <= '0;
      lat_cnt    <= '0;
      res_lo     <= '0;
      in_ready   <= 1'b0;
      core_enc   <= 1'b0;
      core_pt    <= '0;
      core_key   <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      key_loaded <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      key_cnt    <= key_cnt_n;
      blk_cnt    <= blk_cnt_n;
      key_sr     <= key_sr_n;
      blk_sr     <= blk_sr_n;
      lat_cnt    <= lat_cnt_n;
      res_lo     <= res_lo_n;
      in_ready   <= in_ready_n;
      core_enc   <= core_enc_n;
      core_pt    <= core_pt_n;
      core_key   <= core_key_n;
      out_valid  <= out_valid_n;
      out_data   <= out_data_n;
      out_last   <= out_last_n;
      key_loaded <= key_loaded_n;
      err        <= err_n;
    end
  end

endmodule
